int_seq: RTL and testbench

Interrupt and reset entry sequencer for the 6502 core. Arbitrates RESET, NMI, IRQ and software BRK. Drives the shared 7-cycle entry sequence into the datapath: forced BRK opcode, three stack pushes, and a two-byte vector fetch. Sits beside opcode decode: it replaces the fetched opcode with 8'h00 when a hardware interrupt is taken, then sequences the stack and vector cycles.

---
 rtl/int_seq_pkg.sv | 36 +++
 rtl/int_seq_nmi_edge.sv | 28 ++
 rtl/int_seq.sv | 142 ++++++++++++++
 tb/tb_int_seq.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/int_seq_pkg.sv
// Shared definitions for the interrupt/reset entry sequencer: state encoding,
// vector addresses and stack push selectors.
package int_seq_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned PSEL_W = 2;

    typedef enum logic [2:0] {
        INT_IDLE = 3'd0,
        INT_T2   = 3'd1,
        INT_T3   = 3'd2,
        INT_T4   = 3'd3,
        INT_T5   = 3'd4,
        INT_T6   = 3'd5,
        INT_T7   = 3'd6
    } int_state_e;

    localparam logic [ADDR_W-1:0] VEC_NMI = 16'hFFFA;
    localparam logic [ADDR_W-1:0] VEC_RES = 16'hFFFC;
    localparam logic [ADDR_W-1:0] VEC_IRQ = 16'hFFFE;

    localparam logic [PSEL_W-1:0] PUSH_PCH = 2'd0;
    localparam logic [PSEL_W-1:0] PUSH_PCL = 2'd1;
    localparam logic [PSEL_W-1:0] PUSH_P   = 2'd2;

    // Reset outranks NMI; anything else (IRQ or BRK) shares the IRQ vector.
    function automatic logic [ADDR_W-1:0] vec_pick(input logic res, input logic nmi);
        if (res)
            return VEC_RES;
        else if (nmi)
            return VEC_NMI;
        else
            return VEC_IRQ;
    endfunction

endpackage

// File: rtl/int_seq_nmi_edge.sv
// NMI falling-edge detector with a sticky latch; a new edge beats a clear.
module nmi_edge (
    input  logic clk_m2,
    input  logic rst,
    input  logic rdy,
    input  logic nmi_n,
    input  logic clr,
    output logic nmi_lat
);

    logic r_nmi_q;
    logic r_nmi_lat;
    logic w_fall;

    assign w_fall  = r_nmi_q & ~nmi_n;
    assign nmi_lat = r_nmi_lat;

    always_ff @(posedge clk_m2) begin
        if (rst) begin
            r_nmi_q   <= 1'b1;
            r_nmi_lat <= 1'b0;
        end else if (rdy) begin
            r_nmi_q   <= nmi_n;
            r_nmi_lat <= w_fall | (r_nmi_lat & ~clr);
        end
    end

endmodule

// File: rtl/int_seq.sv
// Interrupt/reset entry sequencer: arbitrates RESET, NMI, IRQ and BRK and
// drives the shared seven-cycle entry (inject, three pushes, vector fetch).
module int_seq
    import int_seq_pkg::*;
(
    input  logic              clk_m2,
    input  logic              rst,
    input  logic              rdy,
    input  logic              nmi_n,
    input  logic              irq_n,
    input  logic              p_i,
    input  logic              sync,
    input  logic              brk_op,
    output logic              op_inject,
    output logic              pc_hold,
    output logic              seq_busy,
    output logic              push_en,
    output logic [PSEL_W-1:0] push_sel,
    output logic              b_flag,
    output logic              vec_rd,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              set_i,
    output logic              nmi_ack
);

    int_state_e        r_state;
    int_state_e        w_state_nxt;
    logic              r_hw_src;
    logic              r_res_pend;
    logic [ADDR_W-1:0] r_vsel;

    logic w_nmi_lat;
    logic w_nmi_clr;
    logic w_irq_req;
    logic w_hw_req;
    logic w_take;

    nmi_edge u_nmi_edge (
        .clk_m2  (clk_m2),
        .rst     (rst),
        .rdy     (rdy),
        .nmi_n   (nmi_n),
        .clr     (w_nmi_clr),
        .nmi_lat (w_nmi_lat)
    );

    always_ff @(posedge clk_m2) begin
        if (rst)
            r_state <= INT_IDLE;
        else if (rdy)
            r_state <= w_state_nxt;
    end

    // Per-sequence context: source kind, latched vector, pending reset.
    always_ff @(posedge clk_m2) begin
        if (rst) begin
            r_hw_src   <= 1'b0;
            r_res_pend <= 1'b1;
            r_vsel     <= VEC_IRQ;
        end else if (rdy) begin
            if (w_take)
                r_hw_src <= w_hw_req;
            if (r_state == INT_T4)
                r_vsel <= vec_pick(r_res_pend, w_nmi_lat);
            if (r_state == INT_T7 && r_vsel == VEC_RES)
                r_res_pend <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_nmi_clr   = 1'b0;
        w_irq_req   = ~irq_n & ~p_i;
        w_hw_req    = r_res_pend | w_nmi_lat | w_irq_req;
        op_inject   = 1'b0;
        pc_hold     = 1'b0;
        seq_busy    = 1'b0;
        push_en     = 1'b0;
        push_sel    = PUSH_PCH;
        b_flag      = 1'b0;
        vec_rd      = 1'b0;
        vec_addr    = VEC_IRQ;
        set_i       = 1'b0;
        nmi_ack     = 1'b0;

        if (rst) begin
            // Reset is always pending while rst is high.
            op_inject = sync;
            pc_hold   = sync;
        end else begin
            vec_addr = r_vsel;
            seq_busy = (r_state != INT_IDLE);
            unique case (r_state)
                INT_IDLE: begin
                    if (sync && w_hw_req) begin
                        op_inject = 1'b1;
                        pc_hold   = 1'b1;
                    end
                    if (sync && (w_hw_req || brk_op)) begin
                        w_take      = 1'b1;
                        w_state_nxt = INT_T2;
                    end
                end
                INT_T2: begin
                    pc_hold     = r_hw_src;
                    w_state_nxt = INT_T3;
                end
                INT_T3: begin
                    push_en     = ~r_res_pend;
                    push_sel    = PUSH_PCH;
                    w_state_nxt = INT_T4;
                end
                INT_T4: begin
                    push_en     = ~r_res_pend;
                    push_sel    = PUSH_PCL;
                    w_state_nxt = INT_T5;
                end
                INT_T5: begin
                    push_en     = ~r_res_pend;
                    push_sel    = PUSH_P;
                    b_flag      = ~r_hw_src;
                    w_state_nxt = INT_T6;
                end
                INT_T6: begin
                    vec_rd      = 1'b1;
                    set_i       = 1'b1;
                    w_state_nxt = INT_T7;
                end
                INT_T7: begin
                    vec_rd      = 1'b1;
                    vec_addr    = ADDR_W'(r_vsel + 16'd1);
                    nmi_ack     = (r_vsel == VEC_NMI);
                    w_nmi_clr   = (r_vsel == VEC_NMI) && rdy;
                    w_state_nxt = INT_IDLE;
                end
                default: w_state_nxt = INT_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq: a cycle-position model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_int_seq;

    logic        clk_m2 = 1'b0;
    logic        rst, rdy, nmi_n, irq_n, p_i, sync, brk_op;
    logic        op_inject, pc_hold, seq_busy, push_en, b_flag, vec_rd, set_i, nmi_ack;
    logic [1:0]  push_sel;
    logic [15:0] vec_addr;

    int n_chk  = 0;
    int n_fail = 0;

    int_seq dut (
        .clk_m2    (clk_m2),
        .rst       (rst),
        .rdy       (rdy),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .p_i       (p_i),
        .sync      (sync),
        .brk_op    (brk_op),
        .op_inject (op_inject),
        .pc_hold   (pc_hold),
        .seq_busy  (seq_busy),
        .push_en   (push_en),
        .push_sel  (push_sel),
        .b_flag    (b_flag),
        .vec_rd    (vec_rd),
        .vec_addr  (vec_addr),
        .set_i     (set_i),
        .nmi_ack   (nmi_ack)
    );

    always #5 clk_m2 = ~clk_m2;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the entry sequence (0 = idle, 2..7 = T2..T7).
    int          m_pos     = 0;
    bit          m_res     = 1'b1;
    bit          m_nmi     = 1'b0;
    bit          m_prev    = 1'b1;
    bit          m_hw      = 1'b0;
    logic [15:0] m_vec     = 16'hFFFE;
    bit          m_live    = 1'b0;

    always @(posedge clk_m2) begin
        bit fall, ack, irq_req;
        if (rst) begin
            m_pos = 0; m_res = 1; m_nmi = 0; m_prev = 1; m_hw = 0; m_vec = 16'hFFFE;
            m_live = 1;
        end else if (rdy) begin
            fall    = m_prev && !nmi_n;
            ack     = (m_pos == 7) && (m_vec == 16'hFFFA);
            irq_req = !irq_n && !p_i;
            m_prev  = nmi_n;
            if (m_pos == 0) begin
                if (sync && (m_res || m_nmi || irq_req || brk_op)) begin
                    m_pos = 2;
                    m_hw  = m_res || m_nmi || irq_req;
                end
            end else if (m_pos == 4) begin
                m_vec = m_res ? 16'hFFFC : (m_nmi ? 16'hFFFA : 16'hFFFE);
                m_pos = 5;
            end else if (m_pos == 7) begin
                if (m_vec == 16'hFFFC) m_res = 0;
                m_pos = 0;
            end else begin
                m_pos = m_pos + 1;
            end
            m_nmi = fall || (m_nmi && !ack);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_m2) begin
        bit act_seq, e_inj;
        if (m_live) begin
            act_seq = !rst && m_pos != 0;
            e_inj   = rst ? sync
                          : (sync && m_pos == 0 && (m_res || m_nmi || (!irq_n && !p_i)));
            chk("m_op_inject", 16'(op_inject), 16'(e_inj));
            chk("m_pc_hold",   16'(pc_hold),   16'(e_inj || (!rst && m_pos == 2 && m_hw)));
            chk("m_seq_busy",  16'(seq_busy),  16'(act_seq));
            chk("m_push_en",   16'(push_en),   16'(!rst && m_pos >= 3 && m_pos <= 5 && !m_res));
            chk("m_push_sel",  16'(push_sel),  rst ? 16'd0 : (m_pos == 4 ? 16'd1 : (m_pos == 5 ? 16'd2 : 16'd0)));
            chk("m_b_flag",    16'(b_flag),    16'(!rst && m_pos == 5 && !m_hw));
            chk("m_vec_rd",    16'(vec_rd),    16'(!rst && (m_pos == 6 || m_pos == 7)));
            chk("m_vec_addr",  vec_addr,       rst ? 16'hFFFE : (m_pos == 7 ? 16'(m_vec + 16'd1) : m_vec));
            chk("m_set_i",     16'(set_i),     16'(!rst && m_pos == 6));
            chk("m_nmi_ack",   16'(nmi_ack),   16'(!rst && m_pos == 7 && m_vec == 16'hFFFA));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_m2);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; rdy = 1; sync = 0; nmi_n = 1; irq_n = 1; p_i = 1; brk_op = 0;

        // Reset release and reset sequence
        cyc(2);
        chk("rst_vec_addr", vec_addr, 16'hFFFE);
        chk("rst_busy", 16'(seq_busy), 16'd0);
        sync = 1; #1;
        chk("rst_inject", 16'(op_inject), 16'd1);
        rst = 0; #1;
        chk("res_inject", 16'(op_inject), 16'd1);
        chk("res_pc_hold", 16'(pc_hold), 16'd1);
        cyc(); sync = 0;
        chk("res_t2_hold", 16'(pc_hold), 16'd1);
        cyc();
        chk("res_t3_push", 16'(push_en), 16'd0);
        chk("res_t3_busy", 16'(seq_busy), 16'd1);
        cyc(2);
        chk("res_t5_push", 16'(push_en), 16'd0);
        cyc();
        chk("res_t6_vec", vec_addr, 16'hFFFC);
        chk("res_t6_seti", 16'(set_i), 16'd1);
        cyc();
        chk("res_t7_vec", vec_addr, 16'hFFFD);
        cyc(); sync = 1; #1;
        chk("res_cleared", 16'(op_inject), 16'd0);
        cyc(); sync = 0;
        chk("idle_after_res", 16'(seq_busy), 16'd0);

        // Unmasked IRQ
        p_i = 0; irq_n = 0; sync = 1; #1;
        chk("irq_inject", 16'(op_inject), 16'd1);
        cyc(); sync = 0;
        cyc();
        chk("irq_t3_en", 16'(push_en), 16'd1);
        chk("irq_t3_sel", 16'(push_sel), 16'd0);
        cyc();
        chk("irq_t4_sel", 16'(push_sel), 16'd1);
        cyc();
        chk("irq_t5_sel", 16'(push_sel), 16'd2);
        chk("irq_t5_b", 16'(b_flag), 16'd0);
        cyc();
        chk("irq_t6_vec", vec_addr, 16'hFFFE);
        chk("irq_t6_seti", 16'(set_i), 16'd1);
        irq_n = 1; p_i = 1;
        cyc();
        chk("irq_t7_vec", vec_addr, 16'hFFFF);
        cyc();

        // Masked IRQ: no sequence
        irq_n = 0; sync = 1; #1;
        chk("mask_inject", 16'(op_inject), 16'd0);
        cyc(); sync = 0; irq_n = 1;
        chk("mask_busy", 16'(seq_busy), 16'd0);

        // Software BRK
        brk_op = 1; sync = 1; #1;
        chk("brk_inject", 16'(op_inject), 16'd0);
        cyc(); brk_op = 0; sync = 0;
        chk("brk_t2_hold", 16'(pc_hold), 16'd0);
        chk("brk_t2_busy", 16'(seq_busy), 16'd1);
        cyc(3);
        chk("brk_t5_b", 16'(b_flag), 16'd1);
        cyc();
        chk("brk_t6_vec", vec_addr, 16'hFFFE);
        cyc();
        chk("brk_t7_vec", vec_addr, 16'hFFFF);
        cyc();

        // NMI hijacks a BRK in progress
        brk_op = 1; sync = 1;
        cyc(); brk_op = 0; sync = 0;
        cyc(); nmi_n = 0;
        cyc(2);
        chk("hij_t5_b", 16'(b_flag), 16'd1);
        cyc();
        chk("hij_t6_vec", vec_addr, 16'hFFFA);
        cyc();
        chk("hij_t7_vec", vec_addr, 16'hFFFB);
        chk("hij_t7_ack", 16'(nmi_ack), 16'd1);
        cyc();
        chk("hij_ack_done", 16'(nmi_ack), 16'd0);
        sync = 1; #1;
        chk("hij_lat_clear", 16'(op_inject), 16'd0);
        cyc(); sync = 0; nmi_n = 1;

        // rdy stall in T4 with an NMI edge inside the stall
        brk_op = 1; sync = 1;
        cyc(); brk_op = 0; sync = 0;
        cyc(2); rdy = 0;
        cyc();
        chk("stall_sel", 16'(push_sel), 16'd1);
        chk("stall_busy", 16'(seq_busy), 16'd1);
        nmi_n = 0;
        cyc(2);
        chk("stall_sel_end", 16'(push_sel), 16'd1);
        rdy = 1;
        cyc();
        chk("stall_t5_sel", 16'(push_sel), 16'd2);
        cyc();
        chk("stall_t6_vec", vec_addr, 16'hFFFE);
        cyc(2); sync = 1; #1;
        chk("stall_nmi_inject", 16'(op_inject), 16'd1);
        cyc(); sync = 0;
        cyc(4);
        chk("stall_nmi_vec", vec_addr, 16'hFFFA);
        cyc();
        chk("stall_nmi_ack", 16'(nmi_ack), 16'd1);
        cyc(); nmi_n = 1;

        // rst mid-sequence aborts and restarts the reset sequence
        brk_op = 1; sync = 1;
        cyc(); brk_op = 0; sync = 0;
        cyc(2); rst = 1; #1;
        chk("abort_push", 16'(push_en), 16'd0);
        chk("abort_busy", 16'(seq_busy), 16'd0);
        cyc(); rst = 0; sync = 1; #1;
        chk("abort_inject", 16'(op_inject), 16'd1);
        cyc(); sync = 0;
        cyc(4);
        chk("abort_res_vec", vec_addr, 16'hFFFC);
        cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
